// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: a five-phase FSM that decodes the registered IR
// and raises each datapath write enable only in the phase that owns it.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RegWr,
  output logic       MemWr,
  output logic [1:0] Extop,
  output logic       ALUSrc,
  output logic [2:0] ALUop,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] NPCop,
  output logic [2:0] state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXE    = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  typedef enum logic [3:0] {
    I_NOP, I_ADDU, I_SUBU, I_JR, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_J, I_JAL
  } instr_t;

  logic [2:0] state_q, state_d;
  instr_t     instr;

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    instr = I_NOP;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100001: instr = I_ADDU;
          6'b100011: instr = I_SUBU;
          6'b001000: instr = I_JR;
          default:   instr = I_NOP;
        endcase
      end
      6'b001101: instr = I_ORI;
      6'b100011: instr = I_LW;
      6'b101011: instr = I_SW;
      6'b000100: instr = I_BEQ;
      6'b001111: instr = I_LUI;
      6'b000010: instr = I_J;
      6'b000011: instr = I_JAL;
      default:   instr = I_NOP;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (instr)
          I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ: state_d = S_EXE;
          default:                                         state_d = S_FETCH;
        endcase
      end
      S_EXE: begin
        if (instr == I_BEQ)                       state_d = S_FETCH;
        else if (instr == I_LW || instr == I_SW)  state_d = S_MEM;
        else                                      state_d = S_WB;
      end
      S_MEM:   state_d = (instr == I_LW) ? S_WB : S_FETCH;
      S_WB:    state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    RegWr    = 1'b0;
    MemWr    = 1'b0;
    Extop    = 2'b00;
    ALUSrc   = 1'b0;
    ALUop    = 3'b000;
    RegDst   = 2'b00;
    MemtoReg = 2'b00;
    NPCop    = 2'b00;
    if (!reset) begin
      // Selects depend only on the instruction, so they stay stable across its phases.
      if (state_q <= S_WB) begin
        case (instr)
          I_ADDU:  RegDst = 2'b01;
          I_SUBU:  begin ALUop = 3'b001; RegDst = 2'b01; end
          I_JR:    RegDst = 2'b01;
          I_ORI:   begin ALUSrc = 1'b1; ALUop = 3'b010; end
          I_LW:    begin Extop = 2'b01; ALUSrc = 1'b1; MemtoReg = 2'b01; end
          I_SW:    begin Extop = 2'b01; ALUSrc = 1'b1; end
          I_BEQ:   begin Extop = 2'b01; ALUop = 3'b001; end
          I_LUI:   begin Extop = 2'b10; ALUSrc = 1'b1; end
          I_JAL:   begin RegDst = 2'b10; MemtoReg = 2'b10; end
          default: ;
        endcase
      end
      case (state_q)
        S_FETCH: begin
          IRWr = 1'b1;
          PCWr = 1'b1;
        end
        S_DECODE: begin
          case (instr)
            I_J:     begin PCWr = 1'b1; NPCop = 2'b10; end
            I_JAL:   begin PCWr = 1'b1; NPCop = 2'b10; RegWr = 1'b1; end
            I_JR:    begin PCWr = 1'b1; NPCop = 2'b11; end
            default: ;
          endcase
        end
        S_EXE: begin
          if (instr == I_BEQ) begin
            PCWr  = zero;
            NPCop = 2'b01;
          end
        end
        S_MEM:   MemWr = (instr == I_SW);
        S_WB:    RegWr = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule
